pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
- Measures an incoming PWM waveform: period and high time, in timebase ticks.
- Counterpart of the PWM generator counter: it recovers the carrier and compare values that a generator chain produced.
- Used for loop-back verification of generator channels and for capturing external gate or feedback signals.
- Results are published once per complete period with a single-cycle valid strobe.

Parameters:
COUNTER_WIDTH, 16, width of the period/high-time counters and result outputs; MAX = 2^COUNTER_WIDTH-1

Ports:
clockIn  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  capture enable; low forces IDLE and clears counters
timebase  input  1  count tick; counters advance only on cycles where timebase=1
pwm_in  input  1  asynchronous PWM input
period_out  output  COUNTER_WIDTH  last measured period (ticks, rise-to-rise)
high_out  output  COUNTER_WIDTH  last measured high time (ticks, rise-to-fall)
valid  output  1  one-cycle strobe when period_out/high_out update
timeout  output  1  one-cycle strobe on counter saturation
signal_lost  output  1  level: set by timeout, cleared by next valid
level_out  output  1  synchronized pwm_in, for status

Behaviour:
- Reset (reset=1 at posedge): state IDLE; counters 0; period_out=0; high_out=0; valid=0; timeout=0; signal_lost=0; synchronizer flops 0. Reset has priority over enable and applies mid-measurement.
- Input conditioning: pwm_in passes 2 flops (s1, s2); a third flop s3 holds the previous s2; level_out = s2.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - Fixed 3-cycle input-to-detect latency; it cancels in all measurements.
- States:
  - IDLE: entered on reset or enable=0. Counters held at 0. When enable=1, go to WAIT_RISE next cycle.
  - WAIT_RISE: counters held at 0. On rise, go to HIGH and set cnt = timebase ? 1 : 0. The first period is never published.
  - HIGH: cnt += timebase. On fall, latch high_lat = cnt (excluding that cycle's tick), then cnt += timebase and go to LOW.
  - LOW: cnt += timebase. On rise:
    - commit period_out = cnt (excluding that cycle's tick) and high_out = high_lat;
    - valid=1 for the next cycle only; clear signal_lost;
    - set cnt = timebase ? 1 : 0 and go to HIGH.
- Tick rule: the tick coincident with an edge-detect cycle belongs to the new interval. Result: a period of P ticks reports exactly P regardless of edge alignment.
- Saturation: in HIGH or LOW with cnt == MAX and timebase=1:
  - timeout=1 for one cycle; signal_lost=1;
  - cnt=0 and go to WAIT_RISE;
  - period_out and high_out are unchanged.
  - Saturation check takes priority over a simultaneous edge.
- enable=0 in any state: next state IDLE, cnt=0, high_lat=0, valid=0. period_out, high_out and signal_lost are retained.
- Outputs are registered. valid and timeout are never both asserted.
- Duty 0% or 100% (no edges): reported via timeout/signal_lost, never via valid.
- High time of 0 ticks is legal (edges within one tick interval) and is reported as high_out=0.
- All arithmetic is unsigned COUNTER_WIDTH. There is no wrap-around; saturation detection replaces it.

Test Plan:
- timebase=1 every cycle; pwm_in period 100 clk, high 30 clk, 4 periods -> no valid after first rise; valid once per period thereafter; period_out=100, high_out=30 each time.
- timebase=1 every 4th cycle (random phase); pwm period 400 clk, high 100 clk -> period_out=100, high_out=25 on every valid.
- COUNTER_WIDTH=8, timebase=1 continuously; one rise then pwm_in held high -> timeout pulse exactly 256 cycles after the rise-detect cycle; signal_lost=1; state WAIT_RISE. Restart a 50/20 clk PWM -> second rise gives valid with 50/20 and signal_lost=0.
- reset=1 for 1 cycle in the middle of a HIGH interval -> all outputs 0 next cycle; first valid only after one full subsequent period, with correct values.
- enable dropped for 10 cycles mid-LOW, then re-asserted -> no valid during the drop; outputs retain the last values; the first partial period after re-enable is discarded.
- Glitch-free pulse of 1 clk high inside a 100 clk period, timebase every cycle -> high_out=1, period_out=100.

Source files
------------

// File: rtl/pwm_capture.sv
// PWM capture: measures period (rise-to-rise) and high time (rise-to-fall) of
// pwm_in in timebase ticks and publishes one result per complete period.
//
// state     | meaning
// IDLE      | disabled or just reset; counters held at zero
// WAIT_RISE | armed; first rise starts a measurement that is never published
// HIGH      | counting the high phase; fall latches the high time
// LOW       | counting the low phase; next rise publishes period and high time
module pwm_capture #(
   parameter int COUNTER_WIDTH = 16
) (
   input  logic                     clockIn,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     timebase,
   input  logic                     pwm_in,
   output logic [COUNTER_WIDTH-1:0] period_out,
   output logic [COUNTER_WIDTH-1:0] high_out,
   output logic                     valid,
   output logic                     timeout,
   output logic                     signal_lost,
   output logic                     level_out
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_RISE,
      ST_HIGH,
      ST_LOW
   } state_t;

   localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;

   state_t                   state_q, state_d;
   logic                     s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
   logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
   logic [COUNTER_WIDTH-1:0] high_lat_q, high_lat_d;
   logic [COUNTER_WIDTH-1:0] period_q, period_d;
   logic [COUNTER_WIDTH-1:0] high_q, high_d;
   logic                     valid_q, valid_d;
   logic                     timeout_q, timeout_d;
   logic                     lost_q, lost_d;

   logic                     rise, fall, sat;
   logic [COUNTER_WIDTH-1:0] tick, cnt_inc;

   assign rise    = s2_q & ~s3_q;
   assign fall    = ~s2_q & s3_q;
   assign tick    = {{(COUNTER_WIDTH-1){1'b0}}, timebase};
   assign cnt_inc = cnt_q + tick;
   // A tick that would carry past MAX ends the measurement instead of wrapping.
   assign sat     = timebase & (cnt_q == CNT_MAX);

   always_comb begin
      s1_d       = pwm_in;
      s2_d       = s1_q;
      s3_d       = s2_q;
      state_d    = state_q;
      cnt_d      = cnt_q;
      high_lat_d = high_lat_q;
      period_d   = period_q;
      high_d     = high_q;
      valid_d    = 1'b0;
      timeout_d  = 1'b0;
      lost_d     = lost_q;

      if (!enable) begin
         state_d    = ST_IDLE;
         cnt_d      = '0;
         high_lat_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               cnt_d   = '0;
               state_d = ST_WAIT_RISE;
            end
            ST_WAIT_RISE: begin
               cnt_d = '0;
               if (rise) begin
                  cnt_d   = tick;
                  state_d = ST_HIGH;
               end
            end
            ST_HIGH: begin
               if (sat) begin
                  timeout_d = 1'b1;
                  lost_d    = 1'b1;
                  cnt_d     = '0;
                  state_d   = ST_WAIT_RISE;
               end else if (fall) begin
                  high_lat_d = cnt_q;
                  cnt_d      = cnt_inc;
                  state_d    = ST_LOW;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            ST_LOW: begin
               if (sat) begin
                  timeout_d = 1'b1;
                  lost_d    = 1'b1;
                  cnt_d     = '0;
                  state_d   = ST_WAIT_RISE;
               end else if (rise) begin
                  period_d = cnt_q;
                  high_d   = high_lat_q;
                  valid_d  = 1'b1;
                  lost_d   = 1'b0;
                  cnt_d    = tick;
                  state_d  = ST_HIGH;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            default: begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clockIn) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         s3_q       <= 1'b0;
         cnt_q      <= '0;
         high_lat_q <= '0;
         period_q   <= '0;
         high_q     <= '0;
         valid_q    <= 1'b0;
         timeout_q  <= 1'b0;
         lost_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         s3_q       <= s3_d;
         cnt_q      <= cnt_d;
         high_lat_q <= high_lat_d;
         period_q   <= period_d;
         high_q     <= high_d;
         valid_q    <= valid_d;
         timeout_q  <= timeout_d;
         lost_q     <= lost_d;
      end
   end

   assign period_out  = period_q;
   assign high_out    = high_q;
   assign valid       = valid_q;
   assign timeout     = timeout_q;
   assign signal_lost = lost_q;
   assign level_out   = s2_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: waveforms are built as per-cycle tables and the
// expected results come from summing timebase ticks between detected edges.
module tb_pwm_capture;

   localparam int MAXN = 2048;
   localparam int LAT  = 2;   // edges from pwm_in sample to the edge the FSM acts on

   typedef struct packed {
      int e;
      int per;
      int hi;
   } meas_t;

   logic clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   logic        reset, enable, timebase, pwm_in;
   logic [15:0] period_out, high_out;
   logic        valid, timeout, signal_lost, level_out;
   logic [7:0]  period_out8, high_out8;
   logic        valid8, timeout8, signal_lost8, level_out8;

   pwm_capture #(.COUNTER_WIDTH(16)) dut (
      .clockIn(clk_sys), .reset(reset), .enable(enable), .timebase(timebase),
      .pwm_in(pwm_in), .period_out(period_out), .high_out(high_out),
      .valid(valid), .timeout(timeout), .signal_lost(signal_lost),
      .level_out(level_out)
   );

   pwm_capture #(.COUNTER_WIDTH(8)) dut8 (
      .clockIn(clk_sys), .reset(reset), .enable(enable), .timebase(timebase),
      .pwm_in(pwm_in), .period_out(period_out8), .high_out(high_out8),
      .valid(valid8), .timeout(timeout8), .signal_lost(signal_lost8),
      .level_out(level_out8)
   );

   bit    pw[MAXN];
   bit    tbv[MAXN];
   bit    en[MAXN];
   bit    rs[MAXN];
   bit    rise_at[MAXN+LAT];
   bit    fall_at[MAXN+LAT];
   meas_t exp_q[$];
   meas_t obs_q[$];
   meas_t obs8_q[$];
   int    to_q[$];
   int    to8_q[$];
   int    both_cnt;

   logic [15:0] sn_per, sn_hi;
   logic        sn_valid, sn_to, sn_lost, sn_lvl;
   logic [7:0]  sn_per8, sn_hi8;
   logic        sn_valid8, sn_to8, sn_lost8;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic clear_wave(input int len);
      for (int i = 0; i < len; i++) begin
         pw[i] = 1'b0; tbv[i] = 1'b1; en[i] = 1'b1; rs[i] = 1'b0;
      end
      en[0] = 1'b0;
      en[1] = 1'b0;
   endtask

   task automatic add_pwm(input int at, input int period, input int high, input int nper);
      for (int p = 0; p < nper; p++)
         for (int j = 0; j < high; j++) pw[at + p*period + j] = 1'b1;
   endtask

   task automatic set_tb_div(input int len, input int div, input int phase);
      for (int i = 0; i < len; i++) tbv[i] = (((i + phase) % div) == 0);
   endtask

   function automatic int ticks(input int a, input int b);
      int s = 0;
      for (int i = a; i < b; i++) s += int'(tbv[i]);
      return s;
   endfunction

   // Reference: an edge of pwm_in sampled at edge n is acted on at edge n+LAT.
   // A reset empties the synchronizer, so a level held high afterwards is seen
   // as a fresh rise. Disable/reset discards the running measurement; the FSM
   // is armed again two edges later. Each pair of consecutive captured rises
   // publishes (ticks rise..rise, ticks rise..fall).
   task automatic compute_expected(input int len);
      bit    prev, cur;
      int    start, fall_e, armed;
      meas_t m;
      exp_q.delete();
      for (int i = 0; i < len + LAT; i++) begin rise_at[i] = 0; fall_at[i] = 0; end
      prev = 1'b0;
      for (int n = 0; n < len; n++) begin
         cur = rs[n] ? 1'b0 : pw[n];
         rise_at[n+LAT] = cur & ~prev;
         fall_at[n+LAT] = ~cur & prev;
         prev = cur;
      end
      start = -1; fall_e = -1; armed = 0;
      for (int d = 0; d < len; d++) begin
         if (rs[d] || !en[d]) begin
            start = -1;
            armed = d + 2;
         end else if (d >= armed) begin
            if (fall_at[d] && start >= 0) fall_e = d;
            if (rise_at[d]) begin
               if (start >= 0) begin
                  m.e = d; m.per = ticks(start, d); m.hi = ticks(start, fall_e);
                  exp_q.push_back(m);
               end
               start = d;
            end
         end
      end
   endtask

   task automatic run_wave(input int len, input int snap_e);
      meas_t m;
      obs_q.delete(); obs8_q.delete(); to_q.delete(); to8_q.delete();
      both_cnt = 0;
      for (int i = 0; i <= len; i++) begin
         @(negedge clk_sys);
         if (i > 0) begin
            if (valid) begin
               m.e = i - 1; m.per = int'(period_out); m.hi = int'(high_out);
               obs_q.push_back(m);
            end
            if (valid8) begin
               m.e = i - 1; m.per = int'(period_out8); m.hi = int'(high_out8);
               obs8_q.push_back(m);
            end
            if (timeout)  to_q.push_back(i - 1);
            if (timeout8) to8_q.push_back(i - 1);
            if ((valid && timeout) || (valid8 && timeout8)) both_cnt++;
            if (i - 1 == snap_e) begin
               sn_per = period_out; sn_hi = high_out; sn_valid = valid;
               sn_to = timeout; sn_lost = signal_lost; sn_lvl = level_out;
               sn_per8 = period_out8; sn_hi8 = high_out8; sn_valid8 = valid8;
               sn_to8 = timeout8; sn_lost8 = signal_lost8;
            end
         end
         if (i < len) begin
            reset = rs[i]; enable = en[i]; pwm_in = pw[i]; timebase = tbv[i];
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b1; pwm_in = 1'b1; timebase = 1'b1;
      repeat (3) @(negedge clk_sys);
      n_cmp++;
      if (period_out !== 16'd0 || high_out !== 16'd0) begin
         n_bad++;
         $display("FAIL reset_counts: got period %0d high %0d want 0 0", period_out, high_out);
      end
      n_cmp++;
      if ({valid, timeout, signal_lost, level_out} !== 4'b0) begin
         n_bad++;
         $display("FAIL reset_flags: got v/t/l/lvl %b want 0000", {valid, timeout, signal_lost, level_out});
      end
      n_cmp++;
      if ({period_out8, high_out8, valid8, timeout8, signal_lost8, level_out8} !== 20'd0) begin
         n_bad++;
         $display("FAIL reset_w8: got %0d/%0d/%b want all zero", period_out8, high_out8,
                  {valid8, timeout8, signal_lost8, level_out8});
      end
      pwm_in = 1'b0;
      repeat (3) @(negedge clk_sys);
      reset = 1'b0;
   endtask

   task automatic test_basic();
      int len = 430;
      clear_wave(len);
      add_pwm(10, 100, 30, 4);
      compute_expected(len);
      run_wave(len, -1);
      n_cmp++;
      if (obs_q.size() != exp_q.size() || exp_q.size() != 3) begin
         n_bad++;
         $display("FAIL basic_count: got %0d valids want %0d (3)", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[k]) begin
         meas_t g = (k < obs_q.size()) ? obs_q[k] : '0;
         n_cmp++;
         if (g !== exp_q[k] || g.per != 100 || g.hi != 30) begin
            n_bad++;
            $display("FAIL basic_meas[%0d]: got edge %0d per %0d hi %0d want edge %0d per %0d hi %0d",
                     k, g.e, g.per, g.hi, exp_q[k].e, exp_q[k].per, exp_q[k].hi);
         end
      end
      n_cmp++;
      if (to_q.size() != 0 || both_cnt != 0) begin
         n_bad++;
         $display("FAIL basic_timeout: got %0d timeouts %0d overlaps want 0 0", to_q.size(), both_cnt);
      end
   endtask

   task automatic test_timeout();
      int    len = 460;
      int    d0, x, acc;
      meas_t want;
      clear_wave(len);
      for (int i = 5; i < 305; i++) pw[i] = 1'b1;
      add_pwm(340, 50, 20, 2);
      d0 = 5 + LAT;
      x = -1; acc = 0;
      for (int i = d0; i < len; i++) begin
         acc += int'(tbv[i]);
         if (acc == 256 && x < 0) x = i;
      end
      want.e = 390 + LAT; want.per = ticks(340 + LAT, 390 + LAT); want.hi = ticks(340 + LAT, 360 + LAT);
      run_wave(len, x);
      n_cmp++;
      if (to8_q.size() != 1 || (to8_q.size() == 1 && to8_q[0] != x)) begin
         n_bad++;
         $display("FAIL timeout_edge: got %0d pulses first at %0d want 1 at %0d",
                  to8_q.size(), (to8_q.size() > 0) ? to8_q[0] : -1, x);
      end
      n_cmp++;
      if (sn_to8 !== 1'b1 || sn_lost8 !== 1'b1 || sn_valid8 !== 1'b0) begin
         n_bad++;
         $display("FAIL timeout_flags: got t/lost/v %b%b%b want 110", sn_to8, sn_lost8, sn_valid8);
      end
      n_cmp++;
      if (sn_per8 !== 8'd100 || sn_hi8 !== 8'd30) begin
         n_bad++;
         $display("FAIL timeout_hold: got per %0d hi %0d want 100 30", sn_per8, sn_hi8);
      end
      n_cmp++;
      if (obs8_q.size() != 1 || (obs8_q.size() == 1 && obs8_q[0] !== want)) begin
         n_bad++;
         $display("FAIL timeout_restart: got %0d valids want 1 at edge %0d per %0d hi %0d",
                  obs8_q.size(), want.e, want.per, want.hi);
      end
      n_cmp++;
      if (signal_lost8 !== 1'b0 || both_cnt != 0) begin
         n_bad++;
         $display("FAIL timeout_lost_clear: got lost %b overlaps %0d want 0 0", signal_lost8, both_cnt);
      end
   endtask

   task automatic test_tb_div4();
      int len = 1630;
      clear_wave(len);
      set_tb_div(len, 4, $urandom_range(3, 0));
      add_pwm(10, 400, 100, 4);
      compute_expected(len);
      run_wave(len, -1);
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_bad++;
         $display("FAIL div4_count: got %0d valids want %0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[k]) begin
         meas_t g = (k < obs_q.size()) ? obs_q[k] : '0;
         n_cmp++;
         if (g !== exp_q[k] || g.per != 100 || g.hi != 25) begin
            n_bad++;
            $display("FAIL div4_meas[%0d]: got edge %0d per %0d hi %0d want edge %0d per %0d hi %0d",
                     k, g.e, g.per, g.hi, exp_q[k].e, exp_q[k].per, exp_q[k].hi);
         end
      end
   endtask

   task automatic test_reset_mid();
      int len = 560;
      clear_wave(len);
      add_pwm(10, 100, 50, 5);
      rs[230] = 1'b1;
      compute_expected(len);
      run_wave(len, 230);
      n_cmp++;
      if (sn_per !== 16'd0 || sn_hi !== 16'd0 || {sn_valid, sn_to, sn_lost, sn_lvl} !== 4'b0) begin
         n_bad++;
         $display("FAIL resetmid_clear: got per %0d hi %0d flags %b want 0 0 0000",
                  sn_per, sn_hi, {sn_valid, sn_to, sn_lost, sn_lvl});
      end
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_bad++;
         $display("FAIL resetmid_count: got %0d valids want %0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[k]) begin
         meas_t g = (k < obs_q.size()) ? obs_q[k] : '0;
         n_cmp++;
         if (g !== exp_q[k]) begin
            n_bad++;
            $display("FAIL resetmid_meas[%0d]: got edge %0d per %0d hi %0d want edge %0d per %0d hi %0d",
                     k, g.e, g.per, g.hi, exp_q[k].e, exp_q[k].per, exp_q[k].hi);
         end
      end
   endtask

   task automatic test_enable_drop();
      int len = 560;
      clear_wave(len);
      add_pwm(10, 100, 40, 5);
      for (int i = 270; i < 280; i++) en[i] = 1'b0;
      compute_expected(len);
      run_wave(len, 275);
      n_cmp++;
      if (sn_per !== 16'd100 || sn_hi !== 16'd40 || sn_valid !== 1'b0 || sn_lost !== 1'b0) begin
         n_bad++;
         $display("FAIL endrop_hold: got per %0d hi %0d v %b lost %b want 100 40 0 0",
                  sn_per, sn_hi, sn_valid, sn_lost);
      end
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_bad++;
         $display("FAIL endrop_count: got %0d valids want %0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[k]) begin
         meas_t g = (k < obs_q.size()) ? obs_q[k] : '0;
         n_cmp++;
         if (g !== exp_q[k]) begin
            n_bad++;
            $display("FAIL endrop_meas[%0d]: got edge %0d per %0d hi %0d want edge %0d per %0d hi %0d",
                     k, g.e, g.per, g.hi, exp_q[k].e, exp_q[k].per, exp_q[k].hi);
         end
      end
   endtask

   // Second pass uses a sparse timebase that misses the pulse: high time 0.
   task automatic test_glitch();
      int len = 430;
      for (int g = 0; g < 2; g++) begin
         clear_wave(len);
         if (g == 1) set_tb_div(len, 4, 1);
         add_pwm(10, 100, 1, 4);
         compute_expected(len);
         run_wave(len, -1);
         n_cmp++;
         if (obs_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL glitch%0d_count: got %0d valids want %0d", g, obs_q.size(), exp_q.size());
         end
         foreach (exp_q[k]) begin
            meas_t o = (k < obs_q.size()) ? obs_q[k] : '0;
            n_cmp++;
            if (o !== exp_q[k] || (g == 0 && (o.per != 100 || o.hi != 1))) begin
               n_bad++;
               $display("FAIL glitch%0d_meas[%0d]: got edge %0d per %0d hi %0d want edge %0d per %0d hi %0d",
                        g, k, o.e, o.per, o.hi, exp_q[k].e, exp_q[k].per, exp_q[k].hi);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 4; r++) begin
         int div    = $urandom_range(4, 1);
         int period = $urandom_range(150, 10);
         int high   = $urandom_range(period - 1, 1);
         int len    = 10 + period*5 + 20;
         clear_wave(len);
         set_tb_div(len, div, $urandom_range(div - 1, 0));
         add_pwm(10, period, high, 5);
         compute_expected(len);
         run_wave(len, -1);
         n_cmp++;
         if (obs_q.size() != exp_q.size() || to_q.size() != 0) begin
            n_bad++;
            $display("FAIL rand%0d_count: got %0d valids %0d timeouts want %0d 0 (div %0d P %0d H %0d)",
                     r, obs_q.size(), to_q.size(), exp_q.size(), div, period, high);
         end
         foreach (exp_q[k]) begin
            meas_t o = (k < obs_q.size()) ? obs_q[k] : '0;
            n_cmp++;
            if (o !== exp_q[k]) begin
               n_bad++;
               $display("FAIL rand%0d_meas[%0d]: got edge %0d per %0d hi %0d want edge %0d per %0d hi %0d",
                        r, k, o.e, o.per, o.hi, exp_q[k].e, exp_q[k].per, exp_q[k].hi);
            end
         end
      end
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; timebase = 1'b0; pwm_in = 1'b0;
      test_reset();
      test_basic();
      test_timeout();
      test_tb_div4();
      test_reset_mid();
      test_enable_drop();
      test_glitch();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
